// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
package hazard_stall_controller_pkg;

  // Architectural register-address width (RV32: 32 registers).
  localparam int unsigned REG_ADDR_WIDTH = 5;

  // x0 is hard-wired to zero, so a write to it never creates a hazard.
  localparam int unsigned X0_ADDR = 0;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MD_WAIT  = 2'd1,
    S_MEM_WAIT = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection: a load in Execute whose rd is read
// by the instruction in Decode cannot be covered by forwarding.
module load_use_detect
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH
) (
  input  logic [RegAddrWidth-1:0] rs1,
  input  logic [RegAddrWidth-1:0] rs2,
  input  logic                    rs1_used,
  input  logic                    rs2_used,
  input  logic [RegAddrWidth-1:0] ex_rd,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  output logic                    load_use
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // Match the load destination against each operand the Decode instruction reads.
  always_comb begin
    rd_nonzero = (ex_rd != RegAddrWidth'(X0_ADDR));
    rs1_hit    = rs1_used && (rs1 == ex_rd);
    rs2_hit    = rs2_used && (rs2 == ex_rd);
    load_use   = ex_mem_read && ex_reg_write && rd_nonzero && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central pipeline sequencer: load-use stalls, mul/div and data-memory waits,
// and wrong-path flush on taken branches resolved in Execute.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH,
  parameter int unsigned CountWidth   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RegAddrWidth-1:0] IF_ID_RS1,
  input  logic [RegAddrWidth-1:0] IF_ID_RS2,
  input  logic                    IF_ID_RS1_used,
  input  logic                    IF_ID_RS2_used,
  input  logic [RegAddrWidth-1:0] WriteBack_reg_Execute_stage,
  input  logic                    Reg_File_EN_Execute_stage,
  input  logic                    Mem_Read_EN_Execute_stage,
  input  logic                    Branch_taken_Execute_stage,
  input  logic                    MulDiv_req_Execute_stage,
  input  logic                    MulDiv_done,
  input  logic                    Dmem_req,
  input  logic                    Dmem_ack,
  output logic                    Stall_IF,
  output logic                    Stall_ID,
  output logic                    Stall_EX,
  output logic                    Bubble_EX,
  output logic                    Bubble_MEM,
  output logic                    Flush_IF_ID,
  output logic                    MulDiv_go,
  output logic [CountWidth-1:0]   Stall_count
);

  hazard_state_e state_q;
  hazard_state_e state_d;
  logic          load_use;
  logic          mem_pending;
  logic          mem_complete;

  load_use_detect #(
    .RegAddrWidth(RegAddrWidth)
  ) u_load_use_detect (
    .rs1         (IF_ID_RS1),
    .rs2         (IF_ID_RS2),
    .rs1_used    (IF_ID_RS1_used),
    .rs2_used    (IF_ID_RS2_used),
    .ex_rd       (WriteBack_reg_Execute_stage),
    .ex_reg_write(Reg_File_EN_Execute_stage),
    .ex_mem_read (Mem_Read_EN_Execute_stage),
    .load_use    (load_use)
  );

  // An ack only counts against an outstanding request.
  assign mem_pending  = Dmem_req && !Dmem_ack;
  assign mem_complete = Dmem_req && Dmem_ack;

  // Decision logic: outputs are a zero-cycle function of state and inputs.
  always_comb begin
    state_d     = state_q;
    Stall_IF    = 1'b0;
    Stall_ID    = 1'b0;
    Stall_EX    = 1'b0;
    Bubble_EX   = 1'b0;
    Bubble_MEM  = 1'b0;
    Flush_IF_ID = 1'b0;
    MulDiv_go   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_pending) begin
          Stall_IF   = 1'b1;
          Stall_ID   = 1'b1;
          Stall_EX   = 1'b1;
          Bubble_MEM = 1'b1;
          state_d    = S_MEM_WAIT;
        end else if (MulDiv_req_Execute_stage) begin
          MulDiv_go  = 1'b1;
          Stall_IF   = 1'b1;
          Stall_ID   = 1'b1;
          Stall_EX   = 1'b1;
          Bubble_MEM = 1'b1;
          state_d    = S_MD_WAIT;
        end else if (Branch_taken_Execute_stage) begin
          // Decode holds a wrong-path instruction, so any load-use is moot.
          Flush_IF_ID = 1'b1;
          Bubble_EX   = 1'b1;
        end else if (load_use) begin
          // The bubble moves the load on, clearing the hazard next cycle.
          Stall_IF  = 1'b1;
          Stall_ID  = 1'b1;
          Bubble_EX = 1'b1;
        end
      end

      S_MD_WAIT: begin
        if (MulDiv_done) begin
          state_d = S_RUN;
        end else begin
          Stall_IF   = 1'b1;
          Stall_ID   = 1'b1;
          Stall_EX   = 1'b1;
          Bubble_MEM = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (mem_complete) begin
          state_d = S_RUN;
        end else begin
          // Memory stage keeps its access, so no bubble into EX/MEM.
          Stall_IF = 1'b1;
          Stall_ID = 1'b1;
          Stall_EX = 1'b1;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    // Reset forces quiet outputs regardless of clock or inputs.
    if (rst) begin
      state_d     = S_RUN;
      Stall_IF    = 1'b0;
      Stall_ID    = 1'b0;
      Stall_EX    = 1'b0;
      Bubble_EX   = 1'b0;
      Bubble_MEM  = 1'b0;
      Flush_IF_ID = 1'b0;
      MulDiv_go   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Stall_count <= '0;
    end else if (Stall_IF && (Stall_count != {CountWidth{1'b1}})) begin
      Stall_count <= Stall_count + CountWidth'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed scenarios followed
// by randomized traffic, checked against an abstract pipeline model.
module tb_hazard_stall_controller;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, ex_rd;
  logic          rs1_used, rs2_used, ex_rf_en, ex_mem_rd, br_taken;
  logic          md_req, md_done, dmem_req, dmem_ack;
  logic          stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush, md_go;
  logic [CW-1:0] stall_count;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       rf_en;
    logic       mem_rd;
    logic       br;
    logic       md_req;
    logic       md_done;
    logic       dreq;
    logic       dack;
  } stim_t;

  typedef struct packed {
    logic          sif;
    logic          sid;
    logic          sex;
    logic          bex;
    logic          bmem;
    logic          flush;
    logic          go;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: is a mul/div or memory wait in progress, and stall total.
  bit   m_md_busy;
  bit   m_mem_busy;
  int   m_cnt;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .RegAddrWidth(5),
    .CountWidth  (CW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .IF_ID_RS1                  (rs1),
    .IF_ID_RS2                  (rs2),
    .IF_ID_RS1_used             (rs1_used),
    .IF_ID_RS2_used             (rs2_used),
    .WriteBack_reg_Execute_stage(ex_rd),
    .Reg_File_EN_Execute_stage  (ex_rf_en),
    .Mem_Read_EN_Execute_stage  (ex_mem_rd),
    .Branch_taken_Execute_stage (br_taken),
    .MulDiv_req_Execute_stage   (md_req),
    .MulDiv_done                (md_done),
    .Dmem_req                   (dmem_req),
    .Dmem_ack                   (dmem_ack),
    .Stall_IF                   (stall_if),
    .Stall_ID                   (stall_id),
    .Stall_EX                   (stall_ex),
    .Bubble_EX                  (bubble_ex),
    .Bubble_MEM                 (bubble_mem),
    .Flush_IF_ID                (flush),
    .MulDiv_go                  (md_go),
    .Stall_count                (stall_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference behaviour for one cycle, from the pipeline rules.
  function automatic exp_t predict(input stim_t s, input logic r);
    exp_t e;
    bit   lu;
    bit   freeze;
    e = '0;
    if (r) begin
      m_md_busy  = 1'b0;
      m_mem_busy = 1'b0;
      m_cnt      = 0;
      return e;
    end
    e.cnt  = CW'(m_cnt);
    lu     = s.mem_rd && s.rf_en && (s.rd != 0) &&
             ((s.rs1u && s.rs1 == s.rd) || (s.rs2u && s.rs2 == s.rd));
    freeze = 1'b0;
    if (m_md_busy) begin
      if (s.md_done) m_md_busy = 1'b0;
      else begin
        freeze = 1'b1;
        e.bmem = 1'b1;
      end
    end else if (m_mem_busy) begin
      if (s.dreq && s.dack) m_mem_busy = 1'b0;
      else freeze = 1'b1;
    end else if (s.dreq && !s.dack) begin
      freeze     = 1'b1;
      e.bmem     = 1'b1;
      m_mem_busy = 1'b1;
    end else if (s.md_req) begin
      freeze    = 1'b1;
      e.bmem    = 1'b1;
      e.go      = 1'b1;
      m_md_busy = 1'b1;
    end else if (s.br) begin
      e.flush = 1'b1;
      e.bex   = 1'b1;
    end else if (lu) begin
      e.sif = 1'b1;
      e.sid = 1'b1;
      e.bex = 1'b1;
    end
    if (freeze) begin
      e.sif = 1'b1;
      e.sid = 1'b1;
      e.sex = 1'b1;
    end
    if (e.sif && m_cnt < (1 << CW) - 1) m_cnt++;
    return e;
  endfunction

  // Drive one cycle of inputs just after the edge and queue the expectation.
  task automatic apply(input stim_t s, input logic r);
    @(posedge clk);
    #1;
    rst       = r;
    rs1       = s.rs1;
    rs2       = s.rs2;
    rs1_used  = s.rs1u;
    rs2_used  = s.rs2u;
    ex_rd     = s.rd;
    ex_rf_en  = s.rf_en;
    ex_mem_rd = s.mem_rd;
    br_taken  = s.br;
    md_req    = s.md_req;
    md_done   = s.md_done;
    dmem_req  = s.dreq;
    dmem_ack  = s.dack;
    q.push_back(predict(s, r));
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("outputs", {25'd0, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush, md_go},
              {25'd0, e.sif, e.sid, e.sex, e.bex, e.bmem, e.flush, e.go});
        check("stall_count", {24'd0, stall_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    stim_t idle, s;
    idle = '0;
    rst = 1'b1;
    {rs1, rs2, ex_rd} = '0;
    {rs1_used, rs2_used, ex_rf_en, ex_mem_rd, br_taken} = '0;
    {md_req, md_done, dmem_req, dmem_ack} = '0;
    #2;
    check("reset_outputs", {25'd0, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush, md_go},
          32'd0);
    check("reset_count", {24'd0, stall_count}, 32'd0);
    apply(idle, 1'b1);
    apply(idle, 1'b0);

    // Load-use on rs1: one stall cycle, then the bubble clears it.
    s = idle; s.mem_rd = 1; s.rf_en = 1; s.rd = 5; s.rs1 = 5; s.rs1u = 1;
    apply(s, 1'b0);
    #1 check("lu_stall", {29'd0, stall_if, stall_id, bubble_ex}, 32'b111);
    s.mem_rd = 0; s.rf_en = 0;
    apply(s, 1'b0);
    #1 check("lu_release", {31'd0, stall_if}, 32'd0);

    // Load to x0, and a match only on an unused rs2: no stall either way.
    s = idle; s.mem_rd = 1; s.rf_en = 1; s.rd = 0; s.rs1 = 0; s.rs1u = 1; s.rs2u = 1;
    apply(s, 1'b0);
    s = idle; s.mem_rd = 1; s.rf_en = 1; s.rd = 5; s.rs2 = 5; s.rs2u = 0; s.rs1 = 3; s.rs1u = 1;
    apply(s, 1'b0);
    apply(idle, 1'b0);
    check("lu_count", {24'd0, stall_count}, 32'd1);

    // Divide: go cycle, 33 wait cycles, done on the following cycle.
    s = idle; s.md_req = 1;
    apply(s, 1'b0);
    #1 check("div_go", {31'd0, md_go}, 32'd1);
    for (int i = 0; i < 33; i++) apply(s, 1'b0);
    s.md_done = 1;
    apply(s, 1'b0);
    #1 check("div_release", {30'd0, stall_if, md_go}, 32'd0);
    apply(idle, 1'b0);
    check("div_count", {24'd0, stall_count}, 32'd35);

    // Memory wait with a branch held in Execute; flush only after the ack.
    s = idle; s.dreq = 1; s.br = 1;
    for (int i = 0; i < 4; i++) apply(s, 1'b0);
    s.dack = 1;
    apply(s, 1'b0);
    s = idle; s.br = 1;
    apply(s, 1'b0);
    #1 check("mem_then_flush", {30'd0, flush, bubble_ex}, 32'b11);
    apply(idle, 1'b0);
    check("mem_count", {24'd0, stall_count}, 32'd39);

    // Branch and load-use together: flush wins, no stall.
    s = idle; s.br = 1; s.mem_rd = 1; s.rf_en = 1; s.rd = 7; s.rs2 = 7; s.rs2u = 1;
    apply(s, 1'b0);
    #1 check("br_over_lu", {29'd0, flush, bubble_ex, stall_if}, 32'b110);
    apply(idle, 1'b0);

    // Reset mid mul/div wait, then a stray done after release.
    s = idle; s.md_req = 1;
    for (int i = 0; i < 4; i++) apply(s, 1'b0);
    apply(s, 1'b1);
    #1 check("rst_abort", {25'd0, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush, md_go},
             32'd0);
    check("rst_abort_count", {24'd0, stall_count}, 32'd0);
    s = idle; s.md_done = 1;
    apply(s, 1'b1);
    apply(s, 1'b0);
    #1 check("stray_done", {30'd0, stall_if, md_go}, 32'd0);
    apply(idle, 1'b0);

    // Randomized traffic; long enough to drive the counter into saturation.
    for (int n = 0; n < 1500; n++) begin
      s.rs1     = 5'($urandom_range(0, 3));
      s.rs2     = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.rs1u    = 1'($urandom_range(0, 1));
      s.rs2u    = 1'($urandom_range(0, 1));
      s.rf_en   = ($urandom_range(0, 99) < 70);
      s.mem_rd  = ($urandom_range(0, 99) < 40);
      s.br      = ($urandom_range(0, 99) < 15);
      s.md_req  = ($urandom_range(0, 99) < 10);
      s.md_done = ($urandom_range(0, 99) < 15);
      s.dreq    = ($urandom_range(0, 99) < 20);
      s.dack    = ($urandom_range(0, 99) < 30);
      apply(s, ($urandom_range(0, 999) < 3));
    end
    apply(idle, 1'b0);
    @(negedge clk);
    #1;
    if (m_cnt == (1 << CW) - 1) check("saturated", {24'd0, stall_count}, 32'd255);
    check("scoreboard_drain", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
